// File: rtl/cam_px_gen.sv
// -----------------------------------------------------------------------------
// cam_px_gen
//
// OV7670-style pixel-stream transmitter. Generates CAM_pclk / CAM_href /
// CAM_vsync / CAM_px_data carrying a QQVGA-sized RGB444 test image, two bytes
// per pixel (byte0 = {4'h0,R}, byte1 = {G,B}). It stands in for the physical
// camera in front of the capture block (cam_read).
//
// Optional feature: define CAM_PX_GEN_FRAME_TAG_EN to build a 12-bit frame
// counter that replaces pixel (0,0) of every frame with the frame number.
//
// Ports:
//   clk          in   generator clock (CAM_xclk domain)
//   rst          in   asynchronous reset, active low
//   en           in   run request, sampled at frame boundaries
//   pattern_sel  in   0 bars, 1 gradient, 2 solid, 3 checker
//   solid_color  in   RGB444 value for pattern 2
//   CAM_pclk     out  pixel clock, clk/2, free running
//   CAM_href     out  line valid
//   CAM_vsync    out  frame sync, active high
//   CAM_px_data  out  byte stream, 8'h00 while href is low
//   busy         out  high from leaving IDLE until returning to IDLE
//   frame_done   out  one-clk pulse when a frame's front porch ends
// -----------------------------------------------------------------------------
module cam_px_gen #(
    parameter int CAM_SCREEN_X = 160,
    parameter int CAM_SCREEN_Y = 120,
    parameter int VSYNC_LINES  = 3,
    parameter int VBP_LINES    = 2,
    parameter int VFP_LINES    = 2,
    parameter int H_BLANK      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] solid_color,
    output logic        CAM_pclk,
    output logic        CAM_href,
    output logic        CAM_vsync,
    output logic [7:0]  CAM_px_data,
    output logic        busy,
    output logic        frame_done
);

    // ------------------------------------------------------------------
    // Geometry
    // ------------------------------------------------------------------
    localparam int LINE_T = 2 * CAM_SCREEN_X + H_BLANK;
    localparam int ACT_T  = 2 * CAM_SCREEN_X;
    localparam int VS_T   = VSYNC_LINES * LINE_T;
    localparam int VBP_T  = VBP_LINES * LINE_T;
    localparam int VFP_T  = VFP_LINES * LINE_T;

    localparam int MAX_A  = (VS_T  > VBP_T)   ? VS_T  : VBP_T;
    localparam int MAX_B  = (VFP_T > ACT_T)   ? VFP_T : ACT_T;
    localparam int MAX_C  = (MAX_A > MAX_B)   ? MAX_A : MAX_B;
    localparam int MAX_T  = (MAX_C > H_BLANK) ? MAX_C : H_BLANK;
    localparam int CW     = $clog2(MAX_T + 1);

    // Gradient reads x[7:4] and y[6:3], so keep at least that many bits.
    localparam int XW     = ($clog2(CAM_SCREEN_X) < 8) ? 8 : $clog2(CAM_SCREEN_X);
    localparam int YW     = ($clog2(CAM_SCREEN_Y) < 7) ? 7 : $clog2(CAM_SCREEN_Y);

    localparam int BAR_W  = CAM_SCREEN_X / 8;
    localparam int BPW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [CW-1:0]  VS_LAST  = CW'(VS_T - 1);
    localparam logic [CW-1:0]  VBP_LAST = CW'(VBP_T - 1);
    localparam logic [CW-1:0]  VFP_LAST = CW'(VFP_T - 1);
    localparam logic [CW-1:0]  ACT_LAST = CW'(ACT_T - 1);
    localparam logic [CW-1:0]  HBL_LAST = CW'(H_BLANK - 1);
    localparam logic [YW-1:0]  Y_LAST   = YW'(CAM_SCREEN_Y - 1);
    localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_ACT,
        S_HBL,
        S_VFP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;        // ticks spent in the current state
    logic [XW-1:0]   x;          // pixel of the byte now on CAM_px_data
    logic [YW-1:0]   y;
    logic            phase;      // 0: byte0 on the bus, 1: byte1
    logic [2:0]      bar;        // x / BAR_W, tracked incrementally
    logic [BPW-1:0]  bar_pos;    // x % BAR_W
    logic [1:0]      pat_q;
    logic [11:0]     solid_q;
`ifdef CAM_PX_GEN_FRAME_TAG_EN
    logic [11:0]     frame_cnt;
`endif

    // The state machine advances on the clk edge where CAM_pclk falls, so
    // the registered outputs are mid-period at every pclk rising edge.
    logic tick;
    assign tick = CAM_pclk;

    // ------------------------------------------------------------------
    // Coordinates of the byte that goes on the bus at the next tick.
    // Outside ACT this is the first byte of the upcoming line, which is
    // only consumed when VBP or HBL hands over to ACT.
    // ------------------------------------------------------------------
    logic [XW-1:0]  nx;
    logic [YW-1:0]  ny;
    logic           nph;
    logic [2:0]     nbar;
    logic [BPW-1:0] nbar_pos;

    always_comb begin
        nx       = '0;
        ny       = '0;
        nph      = 1'b0;
        nbar     = '0;
        nbar_pos = '0;
        if (state == S_ACT) begin
            ny       = y;
            nph      = ~phase;
            nx       = x;
            nbar     = bar;
            nbar_pos = bar_pos;
            if (phase) begin
                nx = x + 1'b1;
                if (bar_pos == BAR_LAST) begin
                    nbar_pos = '0;
                    nbar     = bar + 3'd1;
                end else begin
                    nbar_pos = bar_pos + 1'b1;
                end
            end
        end else if (state == S_HBL) begin
            ny = y + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pattern generator
    // ------------------------------------------------------------------
    logic [11:0] color;
    logic [7:0]  next_byte;

    always_comb begin
        color = 12'h000;
        case (pat_q)
            2'd0:    color = {{4{nbar[2]}}, {4{nbar[1]}}, {4{nbar[0]}}};
            2'd1:    color = {nx[7:4], ny[6:3], nx[3:0]};
            2'd2:    color = solid_q;
            default: color = {12{nx[3] ^ ny[3]}};
        endcase
`ifdef CAM_PX_GEN_FRAME_TAG_EN
        if (nx == '0 && ny == '0)
            color = frame_cnt;
`endif
        next_byte = nph ? color[7:0] : {4'h0, color[11:8]};
    end

    // ------------------------------------------------------------------
    // Frame state machine with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            CAM_pclk    <= 1'b0;
            CAM_href    <= 1'b0;
            CAM_vsync   <= 1'b0;
            CAM_px_data <= 8'h00;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            state       <= S_IDLE;
            cnt         <= '0;
            x           <= '0;
            y           <= '0;
            phase       <= 1'b0;
            bar         <= '0;
            bar_pos     <= '0;
            pat_q       <= '0;
            solid_q     <= '0;
`ifdef CAM_PX_GEN_FRAME_TAG_EN
            frame_cnt   <= '0;
`endif
        end else begin
            CAM_pclk   <= ~CAM_pclk;
            frame_done <= 1'b0;     // held only for the tick's own clk
            if (tick) begin
                case (state)
                    S_IDLE: begin
                        if (en) begin
                            state     <= S_VSYNC;
                            cnt       <= '0;
                            CAM_vsync <= 1'b1;
                            busy      <= 1'b1;
                            pat_q     <= pattern_sel;
                            solid_q   <= solid_color;
                        end
                    end
                    S_VSYNC: begin
                        if (cnt == VS_LAST) begin
                            state     <= S_VBP;
                            cnt       <= '0;
                            CAM_vsync <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_VBP: begin
                        if (cnt == VBP_LAST) begin
                            state       <= S_ACT;
                            cnt         <= '0;
                            CAM_href    <= 1'b1;
                            CAM_px_data <= next_byte;
                            x           <= nx;
                            y           <= ny;
                            phase       <= nph;
                            bar         <= nbar;
                            bar_pos     <= nbar_pos;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_ACT: begin
                        if (cnt == ACT_LAST) begin
                            state       <= S_HBL;
                            cnt         <= '0;
                            CAM_href    <= 1'b0;
                            CAM_px_data <= 8'h00;
                        end else begin
                            cnt         <= cnt + 1'b1;
                            CAM_px_data <= next_byte;
                            x           <= nx;
                            phase       <= nph;
                            bar         <= nbar;
                            bar_pos     <= nbar_pos;
                        end
                    end
                    S_HBL: begin
                        if (cnt == HBL_LAST) begin
                            cnt <= '0;
                            if (y == Y_LAST) begin
                                state <= S_VFP;
                            end else begin
                                state       <= S_ACT;
                                CAM_href    <= 1'b1;
                                CAM_px_data <= next_byte;
                                x           <= nx;
                                y           <= ny;
                                phase       <= nph;
                                bar         <= nbar;
                                bar_pos     <= nbar_pos;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_VFP: begin
                        if (cnt == VFP_LAST) begin
                            cnt        <= '0;
                            frame_done <= 1'b1;
`ifdef CAM_PX_GEN_FRAME_TAG_EN
                            frame_cnt  <= frame_cnt + 12'd1;
`endif
                            // Back-to-back frames skip IDLE; settings are
                            // re-latched here instead.
                            if (en) begin
                                state     <= S_VSYNC;
                                CAM_vsync <= 1'b1;
                                pat_q     <= pattern_sel;
                                solid_q   <= solid_color;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cam_px_gen.sv
// -----------------------------------------------------------------------------
// tb_cam_px_gen
//
// Self-checking bench for cam_px_gen on a reduced geometry (32x10 image) so
// several whole frames fit in a short run. Expected bytes of each frame are
// pushed to a scoreboard queue when the frame's settings are driven and are
// popped by a monitor sampling the bus while CAM_pclk is high. A table of
// hand-derived pixel values is checked against the captured frame buffer.
// -----------------------------------------------------------------------------
module tb_cam_px_gen;

    localparam int X    = 32;
    localparam int Y    = 10;
    localparam int VSL  = 2;
    localparam int VBPL = 1;
    localparam int VFPL = 1;
    localparam int HB   = 4;
    localparam int L         = 2 * X + HB;
    localparam int FRAME_T   = (VSL + VBPL + VFPL + Y) * L;
    localparam int FRAME_CLK = 2 * FRAME_T;
    localparam int VS_T      = VSL * L;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [11:0] solid_color = 12'h000;
    logic        CAM_pclk, CAM_href, CAM_vsync, busy, frame_done;
    logic [7:0]  CAM_px_data;

    always #5 clk = ~clk;

    cam_px_gen #(
        .CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y), .VSYNC_LINES(VSL),
        .VBP_LINES(VBPL), .VFP_LINES(VFPL), .H_BLANK(HB)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
        .solid_color(solid_color), .CAM_pclk(CAM_pclk), .CAM_href(CAM_href),
        .CAM_vsync(CAM_vsync), .CAM_px_data(CAM_px_data), .busy(busy),
        .frame_done(frame_done)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    function automatic logic [11:0] model_px(input int pat, input logic [11:0] sc,
                                             input int px, input int py, input int tag);
        int b;
        logic [11:0] c;
        b = px / (X / 8);
        case (pat)
            0:       c = {((b & 4) != 0) ? 4'hF : 4'h0,
                          ((b & 2) != 0) ? 4'hF : 4'h0,
                          ((b & 1) != 0) ? 4'hF : 4'h0};
            1:       c = {4'(px >> 4), 4'(py >> 3), 4'(px)};
            2:       c = sc;
            default: c = ((((px >> 3) ^ (py >> 3)) & 1) != 0) ? 12'hFFF : 12'h000;
        endcase
`ifdef CAM_PX_GEN_FRAME_TAG_EN
        if (px == 0 && py == 0) c = 12'(tag);
`endif
        return c;
    endfunction

    logic [7:0] sb[$];
    int frame_idx = 0;

    task automatic push_frame(input int pat, input logic [11:0] sc);
        logic [11:0] c;
        for (int yy = 0; yy < Y; yy++)
            for (int xx = 0; xx < X; xx++) begin
                c = model_px(pat, sc, xx, yy, frame_idx);
                sb.push_back({4'h0, c[11:8]});
                sb.push_back(c[7:0]);
            end
        frame_idx++;
    endtask

    // ---------------- monitor ----------------
    logic [7:0] cap [Y][2*X];
    int  cyc = 0, fd_cnt = 0, line = 0, bi = 0;
    int  href_len = 0, href_pulses = 0, vs_len = 0, vs_len_last = 0;
    int  last_fd_cyc = -1;
    logic prev_href = 1'b0, prev_vs = 1'b0, prev_fd = 1'b0, seen_vs = 1'b0;

    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        if (!rst) begin
            line = 0; bi = 0; href_len = 0; href_pulses = 0;
            vs_len = 0; vs_len_last = 0; last_fd_cyc = -1;
            prev_href = 1'b0; prev_vs = 1'b0; prev_fd = 1'b0; seen_vs = 1'b0;
        end else begin
            if (frame_done) begin
                chk("fd_width", prev_fd, 0);
                chk("fd_href_count", href_pulses, Y);
                chk("fd_vsync_len", vs_len_last, VS_T);
                chk("fd_href_low", CAM_href, 0);
                if (last_fd_cyc >= 0) chk("fd_period", cyc - last_fd_cyc, FRAME_CLK);
                last_fd_cyc = cyc;
                href_pulses = 0; line = 0; seen_vs = 1'b0;
                fd_cnt++;
            end
            if (CAM_pclk) begin
                if (CAM_vsync) begin
                    vs_len++;
                    seen_vs = 1'b1;
                end else if (prev_vs) begin
                    vs_len_last = vs_len;
                    vs_len = 0;
                end
                prev_vs = CAM_vsync;
                if (CAM_href) begin
                    if (!prev_href) begin
                        chk("vsync_before_href", seen_vs, 1);
                        href_len = 0;
                        bi = 0;
                    end
                    chk("vsync_in_act", CAM_vsync, 0);
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_empty: got byte %0h, expected none", CAM_px_data);
                    end else begin
                        e = sb.pop_front();
                        chk("px_byte", CAM_px_data, e);
                    end
                    if (line < Y && bi < 2 * X) cap[line][bi] = CAM_px_data;
                    bi++;
                    href_len++;
                end else begin
                    chk("px_idle_zero", CAM_px_data, 0);
                    if (prev_href) begin
                        chk("href_len", href_len, 2 * X);
                        href_pulses++;
                        line++;
                    end
                end
                prev_href = CAM_href;
            end
            prev_fd = frame_done;
        end
    end

    // ---------------- spot-check table ----------------
    typedef struct {
        int         pat;
        int         x;
        int         y;
        logic [7:0] b0;
        logic [7:0] b1;
    } vec_t;

    vec_t tbl[14];

    task automatic spot(input int p);
        for (int i = 0; i < 14; i++)
            if (tbl[i].pat == p) begin
                chk($sformatf("spot_p%0d_x%0d_y%0d_b0", p, tbl[i].x, tbl[i].y),
                    cap[tbl[i].y][2*tbl[i].x], tbl[i].b0);
                chk($sformatf("spot_p%0d_x%0d_y%0d_b1", p, tbl[i].x, tbl[i].y),
                    cap[tbl[i].y][2*tbl[i].x+1], tbl[i].b1);
            end
    endtask

    task automatic wait_fd(input string nm);
        int start;
        int n;
        start = fd_cnt;
        n = 0;
        while (fd_cnt == start && n < FRAME_CLK + 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, fd_cnt != start, 1);
    endtask

    task automatic wait_start(input string nm);
        int n;
        logic pv;
        n = 0;
        pv = CAM_vsync;
        while (!busy && n < 100) begin
            pv = CAM_vsync;
            @(negedge clk);
            n++;
        end
        chk({nm, "_busy"}, busy, 1);
        chk({nm, "_vsync_rise"}, {pv, CAM_vsync}, 2'b01);
        chk({nm, "_pclk_low"}, CAM_pclk, 0);
        chk({nm, "_href_low"}, CAM_href, 0);
    endtask

    task automatic idle_hold(input string nm, input int n);
        int bad;
        int tog;
        logic lp;
        bad = 0;
        tog = 0;
        lp = CAM_pclk;
        repeat (n) begin
            @(negedge clk);
            if (CAM_href !== 1'b0 || CAM_vsync !== 1'b0 || CAM_px_data !== 8'h00 ||
                busy !== 1'b0 || frame_done !== 1'b0) bad++;
            if (CAM_pclk !== lp) tog++;
            lp = CAM_pclk;
        end
        chk({nm, "_outputs_low"}, bad, 0);
        chk({nm, "_pclk_toggles"}, tog, n);
    endtask

    initial begin
        int n;
        tbl[0]  = '{0,  5, 0, 8'h00, 8'h0F};
        tbl[1]  = '{0,  9, 3, 8'h00, 8'hF0};
        tbl[2]  = '{0, 17, 5, 8'h0F, 8'h00};
        tbl[3]  = '{0, 31, 9, 8'h0F, 8'hFF};
        tbl[4]  = '{0,  2, 7, 8'h00, 8'h00};
        tbl[5]  = '{1, 21, 9, 8'h01, 8'h15};
        tbl[6]  = '{1, 31, 3, 8'h01, 8'h0F};
        tbl[7]  = '{1, 10, 8, 8'h00, 8'h1A};
        tbl[8]  = '{2,  7, 4, 8'h0A, 8'h5C};
        tbl[9]  = '{2, 31, 9, 8'h0A, 8'h5C};
        tbl[10] = '{3,  8, 0, 8'h0F, 8'hFF};
        tbl[11] = '{3,  8, 8, 8'h00, 8'h00};
        tbl[12] = '{3,  0, 9, 8'h0F, 8'hFF};
        tbl[13] = '{3,  3, 2, 8'h00, 8'h00};

        // Reset values
        #23;
        chk("rst_pclk", CAM_pclk, 0);
        chk("rst_href", CAM_href, 0);
        chk("rst_vsync", CAM_vsync, 0);
        chk("rst_data", CAM_px_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fd", frame_done, 0);

        @(negedge clk) rst = 1'b1;
        idle_hold("idle_en0", 1000);

        // Four back-to-back frames; settings for frame k+1 change mid-frame k
        pattern_sel = 2'd0;
        en = 1'b1;
        push_frame(0, 12'h000);
        wait_start("start0");

        repeat (FRAME_CLK / 2) @(negedge clk);
        pattern_sel = 2'd1;
        push_frame(1, 12'h000);
        wait_fd("fd_frame0");
        spot(0);

        repeat (FRAME_CLK / 2) @(negedge clk);
        pattern_sel = 2'd2;
        solid_color = 12'hA5C;
        push_frame(2, 12'hA5C);
        wait_fd("fd_frame1");
        spot(1);

        repeat (FRAME_CLK / 2) @(negedge clk);
        pattern_sel = 2'd3;
        solid_color = 12'h123;
        push_frame(3, 12'h123);
        wait_fd("fd_frame2");
        spot(2);

        repeat (FRAME_CLK / 2) @(negedge clk);
        en = 1'b0;
        wait_fd("fd_frame3");
        spot(3);
        chk("stop_busy", busy, 0);
        chk("stop_vsync", CAM_vsync, 0);
        idle_hold("idle_after_stop", 300);
        chk("sb_drained", sb.size(), 0);

        // Asynchronous reset in the middle of line 5
        pattern_sel = 2'd0;
        solid_color = 12'h000;
        en = 1'b1;
        push_frame(0, 12'h000);
        n = 0;
        while (!(line == 5 && CAM_href) && n < 2 * FRAME_CLK) begin
            @(negedge clk);
            n++;
        end
        chk("reach_line5", line == 5 && CAM_href, 1);
        repeat (7) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_pclk", CAM_pclk, 0);
        chk("arst_href", CAM_href, 0);
        chk("arst_vsync", CAM_vsync, 0);
        chk("arst_data", CAM_px_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_fd", frame_done, 0);
        sb.delete();
        frame_idx = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        push_frame(0, 12'h000);
        wait_start("restart");
        en = 1'b0;
        wait_fd("fd_restart");
        spot(0);
        chk("sb_drained_end", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
